operand_streamer: RTL and testbench



---
 rtl/operand_streamer.sv | 125 ++++++++++++
 tb/tb_operand_streamer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_streamer.sv
// Streams a contiguous run of words from a 1-cycle-latency memory onto a valid/ready port.
// Define STREAMER_CHECKSUM_EN to compute a running sum of words accepted on the stream.
module operand_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_qout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic [PTR_W+1:0]      occupancy;
  logic                  push, pop, issue, accept;

  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Credit covers words already buffered plus the one returning from memory;
  // a pop this cycle frees a slot in time for the read's data.
  assign occupancy = {1'b0, count} + (PTR_W+2)'(inflight) - (PTR_W+2)'(pop);
  assign issue     = (state == FETCH) && (remaining != '0) &&
                     (occupancy < (PTR_W+2)'(FIFO_DEPTH));

  assign busy          = (state == FETCH) || (state == DRAIN);
  assign done          = (state == DONE);
  assign mem_read_en   = issue;
  assign mem_read_addr = addr;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (length == '0) ? DONE : FETCH;
        end
      end
      FETCH: if (issue && remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
      DRAIN: if (count == '0 && !inflight) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_qout;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef STREAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)  sum <= '0;
    else if (accept) sum <= '0;
    else if (pop)    sum <= sum + out_data;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: bench-side memory model, stream monitor and
// per-transfer checks of addresses, data, latency, back-pressure and reset abort.
module tb_operand_streamer;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy, done, mem_read_en, out_valid, out_ready;
  logic [15:0] mem_read_addr, mem_qout, out_data, checksum;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] rd_q[$];
  int          rd_cyc[$];
  logic [15:0] acc_q[$];
  int          acc_cyc[$];
  int          done_cnt, done_cyc, first_valid_cyc, outstanding;
  logic [15:0] done_chk;
  logic        done_busy, prev_stall;
  logic [15:0] prev_data;

  operand_streamer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .LEN_WIDTH (16),
    .FIFO_DEPTH(2)
  ) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mem_read_en  (mem_read_en),
    .mem_read_addr(mem_read_addr),
    .mem_qout     (mem_qout),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_read_en) mem_qout <= mem[mem_read_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    rd_cyc.delete();
    acc_q.delete();
    acc_cyc.delete();
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
  endtask

  // Monitor at negedge: inputs were driven just after posedge and hold until the next one.
  always @(negedge clk) begin
    if (!arst_n_in) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (mem_read_en) begin
        check("credit", ((outstanding - int'(out_valid && out_ready)) < 2), 1);
        rd_q.push_back(mem_read_addr);
        rd_cyc.push_back(cyc);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        acc_q.push_back(out_data);
        acc_cyc.push_back(cyc);
      end
      outstanding += int'(mem_read_en) - int'(out_valid && out_ready);
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_chk  = checksum;
        done_busy = busy;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic do_xfer(input logic [15:0] base, input logic [15:0] len,
                         input int mode, input bit intrude);
    int          start_cyc;
    int          tail;
    logic [15:0] exp_sum;
    logic [15:0] a;
    clear_mon();
    @(posedge clk); #1;
    base_addr = base;
    length    = len;
    start     = 1'b1;
    out_ready = 1'b1;
    start_cyc = cyc;
    tail      = -1;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      start     = intrude && (k == 3 || k == 4);
      base_addr = start ? 16'h0200 : base;
      length    = start ? 16'd7 : len;
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (k == 1) begin
        #1;
        check("busy_after_start", busy, (len != 0));
      end
      if (done_cnt > 0 && tail < 0) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("done_seen", (done_cnt > 0), 1);
    check("done_once", done_cnt, 1);
    check("busy_at_done", done_busy, 0);
    check("read_count", rd_q.size(), len);
    check("accept_count", acc_q.size(), len);
    exp_sum = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      if (i < rd_q.size())  check("read_addr", rd_q[i], a);
      if (i < acc_q.size()) check("out_data", acc_q[i], mem[a]);
      exp_sum += mem[a];
    end
`ifdef STREAMER_CHECKSUM_EN
    check("checksum", done_chk, exp_sum);
`else
    check("checksum_tied", done_chk, 0);
`endif
    if (len == 0) begin
      check("zero_len_done_lat", done_cyc - start_cyc, 1);
    end else if (mode == 0 && rd_q.size() == int'(len) && acc_q.size() == int'(len)) begin
      check("read_latency", rd_cyc[0] - start_cyc, 1);
      check("valid_latency", first_valid_cyc - start_cyc, 3);
      check("read_back_to_back", rd_cyc[len-1] - rd_cyc[0], len - 1);
      check("out_back_to_back", acc_cyc[len-1] - acc_cyc[0], len - 1);
      check("done_after_last", (done_cyc > acc_cyc[len-1]) && (done_cyc <= acc_cyc[len-1] + 2), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 3 + 7);
    mem[16'h0010] = 16'd1;
    mem[16'h0011] = 16'd2;
    mem[16'h0012] = 16'd3;
    mem[16'h0013] = 16'd4;

    arst_n_in = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    length    = '0;
    clear_mon();
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_read_en, 0);
    check("rst_rd_addr", mem_read_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk); #3;
    arst_n_in = 1'b1;

    do_xfer(16'h0010, 16'd4, 0, 1'b0);
    do_xfer(16'h0010, 16'd4, 1, 1'b0);
    do_xfer(16'h0100, 16'd0, 0, 1'b0);
    do_xfer(16'hFFFE, 16'd4, 0, 1'b0);
    do_xfer(16'h0030, 16'd4, 1, 1'b1);
    do_xfer(16'h0050, 16'd1, 1, 1'b0);

    // Abort a transfer with reset after two words have been taken.
    clear_mon();
    @(posedge clk); #1;
    base_addr = 16'h0040;
    length    = 16'd8;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && acc_q.size() < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort_two_taken", acc_q.size(), 2);
    #2;
    arst_n_in = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rd_en", mem_read_en, 0);
    check("abort_rd_addr", mem_read_addr, 0);
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_checksum", checksum, 0);
    out_ready = 1'b0;
    @(posedge clk); #3;
    arst_n_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);
    do_xfer(16'h0080, 16'd3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1);
  end

endmodule
